toggle_gen: RTL and testbench

Programmable square-wave generator: the transmit side of the slow single-bit toggle stimulus that our `example`-style DUTs sample on `inA`. After a start request it drives `outA` from a chosen initial level and toggles it every `half_period` clock cycles, for exactly `num_toggles` toggles. It then reports completion with a one-cycle `done` pulse. It replaces behavioural `#delay` toggling in benches with a synthesizable, cycle-exact source.

---
 rtl/toggle_gen.sv | 128 ++++++++++++
 tb/tb_toggle_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/toggle_gen.sv
// rtl/toggle_gen.sv - programmable square-wave generator with start/stop and done pulse
module toggle_gen #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] half_period,
  input  logic [NUM_W-1:0] num_toggles,
  input  logic             init_level,
  input  logic             stop,
  output logic             outA,
  output logic             busy,
  output logic             done,
  output logic             tgl
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NUM_W-1:0] NUM_ONE = {{(NUM_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [CNT_W-1:0] h_q, h_nxt;
  logic [NUM_W-1:0] n_q, n_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [NUM_W-1:0] tcnt_q, tcnt_nxt;
  logic             out_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic             tgl_nxt;

  // Comparisons against H-1 and N-1 (rather than H and N) keep both
  // counters inside their range even at the all-ones parameter values.
  logic             half_end;
  logic             last_toggle;
  assign half_end    = (cnt_q == (h_q - CNT_ONE));
  assign last_toggle = (tcnt_q == (n_q - NUM_ONE));

  // State and output registers; every output is a flop, so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      h_q    <= CNT_ONE;
      n_q    <= '0;
      cnt_q  <= '0;
      tcnt_q <= '0;
      outA   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      tgl    <= 1'b0;
    end else begin
      state  <= state_nxt;
      h_q    <= h_nxt;
      n_q    <= n_nxt;
      cnt_q  <= cnt_nxt;
      tcnt_q <= tcnt_nxt;
      outA   <= out_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      tgl    <= tgl_nxt;
    end
  end

  // Next-state and next-output logic; strobes default low, everything else holds.
  always_comb begin
    state_nxt = state;
    h_nxt     = h_q;
    n_nxt     = n_q;
    cnt_nxt   = cnt_q;
    tcnt_nxt  = tcnt_q;
    out_nxt   = outA;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    tgl_nxt   = 1'b0;

    unique case (state)
      IDLE: begin
        // stop is ignored here; outA keeps its last level until a new run.
        if (start) begin
          h_nxt    = (half_period == '0) ? CNT_ONE : half_period;
          n_nxt    = num_toggles;
          out_nxt  = init_level;
          cnt_nxt  = '0;
          tcnt_nxt = '0;
          if (num_toggles != '0) begin
            state_nxt = RUN;
            busy_nxt  = 1'b1;
          end else begin
            // A zero-length run completes immediately without entering RUN.
            done_nxt = 1'b1;
          end
        end
      end

      RUN: begin
        // start is ignored here so the latched H and N are never disturbed.
        if (stop) begin
          // Abort wins over a toggle due on the same edge; outA freezes.
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else if (half_end) begin
          out_nxt  = ~outA;
          tgl_nxt  = 1'b1;
          cnt_nxt  = '0;
          tcnt_nxt = tcnt_q + NUM_ONE;
          if (last_toggle) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end else begin
          cnt_nxt = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_toggle_gen.sv
// tb/tb_toggle_gen.sv - self-checking bench for toggle_gen
module tb_toggle_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic        stop;
  logic        init_level;
  logic [15:0] half_period;
  logic [7:0]  num_toggles;
  logic [3:0]  hp4;
  logic        outA_a, busy_a, done_a, tgl_a;
  logic        outA_b, busy_b, done_b, tgl_b;

  assign hp4 = half_period[3:0];

  always #5 clk = ~clk;

  toggle_gen #(.CNT_W(16), .NUM_W(8)) dut (
    .clk(clk), .rst(rst), .start(start_a), .half_period(half_period),
    .num_toggles(num_toggles), .init_level(init_level), .stop(stop),
    .outA(outA_a), .busy(busy_a), .done(done_a), .tgl(tgl_a)
  );

  // Narrow-counter instance for the width-extreme case.
  toggle_gen #(.CNT_W(4), .NUM_W(8)) dut4 (
    .clk(clk), .rst(rst), .start(start_b), .half_period(hp4),
    .num_toggles(num_toggles), .init_level(init_level), .stop(stop),
    .outA(outA_b), .busy(busy_b), .done(done_b), .tgl(tgl_b)
  );

  // Expected {outA, busy, done, tgl} after one edge.
  typedef logic [3:0] exp_t;

  typedef struct {
    int hp;
    int nt;
    bit init;
    int stop_at;
    int ign_at;
    bit sel;
    string name;
  } vec_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  bit   cur_sel = 1'b0;

  task automatic push(input logic o, input logic b, input logic d, input logic t);
    sbq.push_back({o, b, d, t});
  endtask

  task automatic step(input string name, input int cyc);
    exp_t e;
    exp_t got;
    @(posedge clk);
    #1;
    got = cur_sel ? {outA_b, busy_b, done_b, tgl_b} : {outA_a, busy_a, done_a, tgl_a};
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s cyc=%0d scoreboard empty, got {outA,busy,done,tgl}=%b", name, cyc, got);
    end else begin
      e = sbq.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL %s cyc=%0d got {outA,busy,done,tgl}=%b expected %b", name, cyc, got, e);
      end
    end
  endtask

  task automatic set_start(input logic v);
    if (cur_sel) start_b = v;
    else         start_a = v;
  endtask

  task automatic scramble;
    logic [31:0] r;
    r = $urandom;
    half_period = r[15:0];
    num_toggles = r[23:16];
    init_level  = r[24];
  endtask

  // Expected waveform comes from the timing rules: after edge E(j) the level is
  // init XOR parity(floor(j/H)), a toggle lands on every multiple of H, and the
  // run ends at E(N*H).
  task automatic run_vec(input vec_t v);
    int   h;
    int   total;
    int   hp;
    int   nt;
    logic lvl;
    logic last_lvl;
    hp = v.hp;
    nt = v.nt;
    h = (hp == 0) ? 1 : hp;
    total = nt * h;
    cur_sel = v.sel;
    half_period = hp[15:0];
    num_toggles = nt[7:0];
    init_level  = v.init;
    set_start(1'b1);
    push(v.init, nt != 0, nt == 0, 1'b0);
    step(v.name, 0);
    set_start(1'b0);
    scramble();
    last_lvl = v.init;
    for (int j = 1; j <= total; j++) begin
      if (j == v.stop_at) begin
        stop = 1'b1;
        push(last_lvl, 1'b0, 1'b0, 1'b0);
        step(v.name, j);
        stop = 1'b0;
        break;
      end
      if (j == v.ign_at) begin
        set_start(1'b1);
        half_period = 16'd1;
        num_toggles = 8'd1;
      end
      lvl = v.init ^ (((j / h) % 2) == 1);
      push(lvl, j < total, j == total, (j % h) == 0);
      step(v.name, j);
      set_start(1'b0);
      last_lvl = lvl;
    end
    // Idle afterwards: level holds, a stop pulse is ignored, no strobes.
    stop = 1'b1;
    push(last_lvl, 1'b0, 1'b0, 1'b0);
    step({v.name, "_idle"}, total + 1);
    stop = 1'b0;
    push(last_lvl, 1'b0, 1'b0, 1'b0);
    step({v.name, "_idle"}, total + 2);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[9];
    exp_t bb[11];
    int   h;
    logic lvl;

    vecs[0] = '{hp: 3,  nt: 4,   init: 1'b0, stop_at: -1, ign_at: -1, sel: 1'b0, name: "basic"};
    vecs[1] = '{hp: 0,  nt: 3,   init: 1'b1, stop_at: -1, ign_at: -1, sel: 1'b0, name: "h_zero"};
    vecs[2] = '{hp: 7,  nt: 0,   init: 1'b1, stop_at: -1, ign_at: -1, sel: 1'b0, name: "n_zero"};
    vecs[3] = '{hp: 5,  nt: 10,  init: 1'b0, stop_at: 7,  ign_at: -1, sel: 1'b0, name: "abort"};
    vecs[4] = '{hp: 3,  nt: 2,   init: 1'b1, stop_at: -1, ign_at: -1, sel: 1'b0, name: "after_abort"};
    vecs[5] = '{hp: 2,  nt: 8,   init: 1'b0, stop_at: -1, ign_at: 3,  sel: 1'b0, name: "ignored_start"};
    vecs[6] = '{hp: 15, nt: 2,   init: 1'b0, stop_at: -1, ign_at: -1, sel: 1'b1, name: "cnt_w4_h15"};
    vecs[7] = '{hp: 1,  nt: 255, init: 1'b1, stop_at: -1, ign_at: -1, sel: 1'b0, name: "n_max"};
    vecs[8] = '{hp: 4,  nt: 1,   init: 1'b0, stop_at: 4,  ign_at: -1, sel: 1'b0, name: "stop_on_toggle"};

    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    stop = 1'b0;
    init_level = 1'b0;
    half_period = '0;
    num_toggles = '0;

    cur_sel = 1'b0;
    push(1'b0, 1'b0, 1'b0, 1'b0);
    step("reset_a", 0);
    cur_sel = 1'b1;
    push(1'b0, 1'b0, 1'b0, 1'b0);
    step("reset_b", 1);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Back-to-back: start held high, second run accepted in the done cycle.
    cur_sel = 1'b0;
    bb[0] = 4'b1100; bb[1] = 4'b1100; bb[2] = 4'b0101; bb[3] = 4'b0100;
    bb[4] = 4'b1011; bb[5] = 4'b1100; bb[6] = 4'b1100; bb[7] = 4'b0101;
    bb[8] = 4'b0100; bb[9] = 4'b1011; bb[10] = 4'b1000;
    half_period = 16'd2;
    num_toggles = 8'd2;
    init_level  = 1'b1;
    start_a = 1'b1;
    for (int j = 0; j < 11; j++) begin
      if (j == 10) start_a = 1'b0;
      sbq.push_back(bb[j]);
      step("back_to_back", j);
    end

    // Reset in the middle of a run.
    h = 4;
    half_period = 16'd4;
    num_toggles = 8'd5;
    init_level  = 1'b1;
    start_a = 1'b1;
    for (int j = 0; j <= 5; j++) begin
      lvl = 1'b1 ^ (((j / h) % 2) == 1);
      push(lvl, 1'b1, 1'b0, (j != 0) && ((j % h) == 0));
      step("pre_reset_run", j);
      start_a = 1'b0;
    end
    rst = 1'b1;
    push(1'b0, 1'b0, 1'b0, 1'b0);
    step("mid_run_reset", 6);
    rst = 1'b0;
    push(1'b0, 1'b0, 1'b0, 1'b0);
    step("post_reset_idle", 7);

    // A normal run after reset.
    run_vec('{hp: 2, nt: 3, init: 1'b1, stop_at: -1, ign_at: -1, sel: 1'b0, name: "after_reset"});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
